generic_pipe: RTL and testbench

- Synchronous FIFO "pipe" moving LENGTH-bit data words from a producer to a consumer using per-word req/ack handshakes on each side.
- Used as the generic inter-stage buffer between Vision_Processor pipeline blocks.
- Word order is strictly preserved. No data is ever lost or duplicated while the handshake rules are obeyed.

---
 rtl/generic_pipe.sv | 79 +++++++
 tb/tb_generic_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/generic_pipe.sv
// Synchronous req/ack FIFO buffer between Vision_Processor pipeline stages.
// Registered acks and read data; full/empty decoded from the stored word count.
module generic_pipe #(
   parameter int unsigned LENGTH = 18,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     pipe_write_ack,
   input  logic                     pipe_write_req,
   input  logic [LENGTH-1:0]        pipe_write_data,
   output logic                     pipe_read_ack,
   input  logic                     pipe_read_req,
   output logic [LENGTH-1:0]        pipe_read_data,
   output logic                     pipe_full,
   output logic                     pipe_empty,
   output logic [$clog2(DEPTH):0]   pipe_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [LENGTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_write_ack;
   logic              r_read_ack;
   logic [LENGTH-1:0] r_read_data;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_en;
   logic              w_rd_en;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   // Acceptance uses the pre-edge flags, so a full pipe never takes a write
   // and an empty pipe never pops, even when both requests are present.
   assign w_wr_en = pipe_write_req && !w_full;
   assign w_rd_en = pipe_read_req  && !w_empty;

   // Storage is not reset; only pointers and count define valid contents.
   always_ff @(posedge clk) begin
      if (!reset && w_wr_en) begin
         r_mem[r_wr_ptr] <= pipe_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_write_ack <= 1'b0;
         r_read_ack  <= 1'b0;
         r_read_data <= '0;
      end else begin
         r_write_ack <= w_wr_en;
         r_read_ack  <= w_rd_en;
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_en) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_read_data <= r_mem[r_rd_ptr];
         end
         r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
      end
   end

   assign pipe_write_ack = r_write_ack;
   assign pipe_read_ack  = r_read_ack;
   assign pipe_read_data = r_read_data;
   assign pipe_count     = r_count;
   assign pipe_full      = w_full;
   assign pipe_empty     = w_empty;

endmodule

// File: tb/tb_generic_pipe.sv
// Bench for generic_pipe: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the FIFO.
module tb_generic_pipe;

   localparam int unsigned LENGTH = 18;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned AW     = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset;
   logic              pipe_write_ack;
   logic              pipe_write_req;
   logic [LENGTH-1:0] pipe_write_data;
   logic              pipe_read_ack;
   logic              pipe_read_req;
   logic [LENGTH-1:0] pipe_read_data;
   logic              pipe_full;
   logic              pipe_empty;
   logic [AW:0]       pipe_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [LENGTH-1:0] model_q [$];
   logic [LENGTH-1:0] exp_rd_data = '0;
   logic              last_wr_rejected = 1'b0;
   logic [LENGTH-1:0] held_data = '0;
   logic [LENGTH-1:0] next_val;

   generic_pipe #(.LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .pipe_write_ack  (pipe_write_ack),
      .pipe_write_req  (pipe_write_req),
      .pipe_write_data (pipe_write_data),
      .pipe_read_ack   (pipe_read_ack),
      .pipe_read_req   (pipe_read_req),
      .pipe_read_data  (pipe_read_data),
      .pipe_full       (pipe_full),
      .pipe_empty      (pipe_empty),
      .pipe_count      (pipe_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, advance the model, then compare all outputs.
   task automatic step(input logic rst, input logic wr, input logic [LENGTH-1:0] wd,
                       input logic rd);
      logic exp_wack;
      logic exp_rack;
      int   sz;
      reset           = rst;
      pipe_write_req  = wr;
      pipe_write_data = wd;
      pipe_read_req   = rd;
      sz = model_q.size();
      if (rst) begin
         exp_wack = 1'b0;
         exp_rack = 1'b0;
         model_q.delete();
         exp_rd_data = '0;
      end else begin
         exp_wack = wr && (sz < DEPTH);
         exp_rack = rd && (sz > 0);
         if (exp_rack) exp_rd_data = model_q.pop_front();
         if (exp_wack) model_q.push_back(wd);
      end
      last_wr_rejected = wr && !exp_wack && !rst;
      held_data        = wd;
      @(posedge clk);
      #1;
      check("write_ack", 32'(pipe_write_ack), 32'(exp_wack));
      check("read_ack",  32'(pipe_read_ack),  32'(exp_rack));
      check("read_data", 32'(pipe_read_data), 32'(exp_rd_data));
      check("count",     32'(pipe_count),     32'(model_q.size()));
      check("full",      32'(pipe_full),      32'(model_q.size() == DEPTH));
      check("empty",     32'(pipe_empty),     32'(model_q.size() == 0));
   endtask

   initial begin
      reset           = 1'b1;
      pipe_write_req  = 1'b0;
      pipe_write_data = '0;
      pipe_read_req   = 1'b0;

      // Basic write/read with a gap where data 3 is presented without req
      step(1, 0, '0, 0);
      step(1, 0, '0, 0);
      step(0, 1, 18'd1, 0);
      step(0, 1, 18'd2, 0);
      step(0, 0, 18'd3, 0);
      step(0, 1, 18'd4, 0);
      step(0, 0, '0, 1);
      check("basic_first_pop", 32'(pipe_read_data), 32'd1);
      step(0, 0, '0, 0);
      step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      check("basic_last_pop", 32'(pipe_read_data), 32'd4);

      // Read while empty: no ack, data holds reset value
      step(1, 0, '0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
      check("empty_hold", 32'(pipe_read_data), 32'd0);

      // Fill, reject a 9th write, then alternate reads and writes across the wrap
      step(1, 0, '0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 18'(32'h10 + i), 0);
      check("full_flag", 32'(pipe_full), 32'd1);
      step(0, 1, 18'h18, 0);
      check("full_no_ack", 32'(pipe_write_ack), 32'd0);
      next_val = 18'h18;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) step(0, 0, '0, 1);
         else begin
            step(0, 1, next_val, 0);
            next_val = next_val + 18'd1;
         end
      end

      // Simultaneous read and write at mid, full and empty levels
      step(1, 0, '0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 18'(32'h20 + i), 0);
      step(0, 1, 18'h23, 1);
      check("simul_mid_count", 32'(pipe_count), 32'd3);
      for (int i = 0; i < 5; i++) step(0, 1, 18'(32'h30 + i), 0);
      step(0, 1, 18'h35, 1);
      check("simul_full_count", 32'(pipe_count), 32'd7);
      step(1, 0, '0, 0);
      step(0, 1, 18'h36, 1);
      check("simul_empty_count", 32'(pipe_count), 32'd1);

      // Reset mid-operation with both requests high
      step(1, 0, '0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 18'(32'h40 + i), 0);
      step(1, 1, 18'h45, 1);
      check("midrst_count", 32'(pipe_count), 32'd0);
      step(0, 1, 18'h2A, 0);
      step(0, 0, '0, 1);
      check("midrst_pop", 32'(pipe_read_data), 32'h2A);

      // Random traffic in phases biased toward filling and draining
      for (int i = 0; i < 2000; i++) begin
         int unsigned wpct;
         logic        wr;
         logic        rd;
         logic        rst;
         logic [LENGTH-1:0] wd;
         wpct = ((i / 100) % 2 == 0) ? 75 : 25;
         rst  = ($urandom_range(0, 299) == 0);
         rd   = ($urandom_range(0, 99) < (100 - wpct));
         if (last_wr_rejected) begin
            wr = 1'b1;
            wd = held_data;
         end else begin
            wr = ($urandom_range(0, 99) < wpct);
            wd = LENGTH'($urandom);
         end
         step(rst, wr, wd, rd);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
